// File: rtl/seq_det_pkg.sv
// Shared constants for the serial pattern detector: 7-segment glyphs, dp index, reset pattern.
// Segment bit order (bit0..bit6) is c,b,a,f,e,d,g, as wired on the target display.
package seq_det_pkg;

   localparam int SEG_DP = 7;

   localparam logic [6:0] SEG_0 = 7'h3F;
   localparam logic [6:0] SEG_1 = 7'h03;
   localparam logic [6:0] SEG_2 = 7'h76;
   localparam logic [6:0] SEG_3 = 7'h67;
   localparam logic [6:0] SEG_4 = 7'h4B;
   localparam logic [6:0] SEG_5 = 7'h6D;
   localparam logic [6:0] SEG_6 = 7'h7D;
   localparam logic [6:0] SEG_7 = 7'h07;
   localparam logic [6:0] SEG_8 = 7'h7F;
   localparam logic [6:0] SEG_9 = 7'h6F;
   localparam logic [6:0] SEG_A = 7'h5F;
   localparam logic [6:0] SEG_B = 7'h79;
   localparam logic [6:0] SEG_C = 7'h3C;
   localparam logic [6:0] SEG_D = 7'h73;
   localparam logic [6:0] SEG_E = 7'h7C;
   localparam logic [6:0] SEG_F = 7'h5C;

   localparam logic [15:0][6:0] SEG_HEX = {SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
                                           SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0};

   localparam logic [7:0] DEF_RST_PATTERN = 8'b0000_0100;
   localparam int         DEF_RST_LEN     = 3;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to 7-segment decode, segments active high.
module seg7_hex_decode
   import seq_det_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] segs
);

   assign segs = SEG_HEX[nibble];

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial pattern detector with saturating match counter and 7-seg output.
// match is registered on the same edge that shifts in the completing bit.
module seq_detector_param
   import seq_det_pkg::*;
#(
   parameter int                PAT_W       = 8,
   parameter int                CNT_W       = 8,
   parameter int                LEN_W       = 4,
   parameter logic [PAT_W-1:0]  RST_PATTERN = PAT_W'(DEF_RST_PATTERN),
   parameter logic [LEN_W-1:0]  RST_LEN     = LEN_W'(DEF_RST_LEN)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic             din_valid,
   input  logic             din,
   input  logic             cfg_load,
   input  logic [PAT_W-1:0] cfg_pattern,
   input  logic [LEN_W-1:0] cfg_len,
   input  logic             cfg_overlap,
   output logic             match,
   output logic [CNT_W-1:0] match_count,
   output logic [7:0]       seg
);

   localparam logic [LEN_W-1:0] FULL    = LEN_W'(PAT_W);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [PAT_W-1:0] hist, hist_nx, pat, mask;
   logic [LEN_W-1:0] fill, fill_nx, len, len_clamped;
   logic             overlap, sample, hit;
   logic [6:0]       digit_segs;

   always_comb begin
      mask        = '0;
      sample      = din_valid && !cfg_load;
      hist_nx     = {hist[PAT_W-2:0], din};
      fill_nx     = (fill >= FULL) ? FULL : fill + 1'b1;
      for (int i = 0; i < PAT_W; i++) begin
         mask[i] = (i < int'(len));
      end
      hit         = sample && (fill_nx >= len) && (((hist_nx ^ pat) & mask) == '0);
      len_clamped = (cfg_len == '0) ? LEN_W'(1) : ((cfg_len > FULL) ? FULL : cfg_len);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist        <= '0;
         fill        <= '0;
         pat         <= RST_PATTERN;
         len         <= RST_LEN;
         overlap     <= 1'b1;
         match       <= 1'b0;
         match_count <= '0;
      end else if (ena) begin
         if (cfg_load) begin
            pat         <= cfg_pattern;
            len         <= len_clamped;
            overlap     <= cfg_overlap;
            hist        <= '0;
            fill        <= '0;
            match       <= 1'b0;
            match_count <= '0;
         end else begin
            match <= hit;
            if (sample) begin
               hist <= hist_nx;
               // Non-overlapping mode restarts fill so the next hit needs len fresh bits.
               fill <= (hit && !overlap) ? '0 : fill_nx;
            end
            if (hit && match_count != CNT_MAX) begin
               match_count <= match_count + 1'b1;
            end
         end
      end
   end

   seg7_hex_decode u_dec (
      .nibble (match_count[3:0]),
      .segs   (digit_segs)
   );

   assign seg = {match, digit_segs};

endmodule
